if_fetch_unit: RTL

Instruction fetch stage of the 5-stage RV32I pipeline. It produces the `if_instruction` / `if_pc_plus_4` pair consumed by the IF/ID pipeline register. It owns the PC, talks to instruction memory over a single-outstanding request/response handshake, and holds a one-entry output buffer that honours the hazard unit's `stall`. Branch/jump redirects from EX discard wrong-path fetches, including a response still in flight.

---
 rtl/if_fetch_unit_pkg.sv | 19 +
 rtl/if_fetch_unit.sv | 96 +++++++++
 2 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: default reset PC,
// bubble instruction, FSM state encoding and address helpers.
package if_fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // Clear the byte offset of a fetch target.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// RV32I instruction fetch stage: owns the PC, issues single-outstanding
// instruction memory requests, and holds a one-entry output buffer that
// honours the hazard-unit stall. Redirects discard wrong-path fetches.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSN = DEFAULT_NOP_INSN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc_plus_4,
  output logic        if_valid
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  inst_q;
  logic [31:0]  pc4_q;
  logic         valid_q;

  logic         accept;
  logic         fill;
  logic [31:0]  pc_plus_4;

  assign accept    = imem_req && imem_ready;
  // A response is kept only when waiting on a live request and no redirect
  // has made it wrong-path in the same cycle.
  assign fill      = (state_q == WAIT) && imem_rvalid && !redirect;
  assign pc_plus_4 = pc_q + 32'd4;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= REQ;
    else       state_q <= state_d;
  end

  // FSM next-state: track whether an accepted request is live or stale
  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ: begin
        if (accept) state_d = redirect ? DROP : WAIT;
      end
      WAIT: begin
        if (redirect)         state_d = imem_rvalid ? REQ : DROP;
        else if (imem_rvalid) state_d = REQ;
      end
      DROP: begin
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  // FSM outputs and buffer presentation
  always_comb begin
    imem_req       = !reset && (state_q == REQ) && (!valid_q || !stall);
    imem_addr      = pc_q;
    if_valid       = valid_q;
    if_instruction = valid_q ? inst_q : NOP_INSN;
    if_pc_plus_4   = valid_q ? pc4_q  : '0;
  end

  // PC and output buffer: redirect wins over fill, fill over consume
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      inst_q  <= '0;
      pc4_q   <= '0;
    end else begin
      if (redirect)  pc_q <= word_align(redirect_pc);
      else if (fill) pc_q <= pc_plus_4;

      if (redirect)    valid_q <= 1'b0;
      else if (fill)   valid_q <= 1'b1;
      else if (!stall) valid_q <= 1'b0;

      if (fill) begin
        inst_q <= imem_rdata;
        pc4_q  <= pc_plus_4;
      end
    end
  end

endmodule
